// File: rtl/sdram_probe_pkg.sv
// Shared types and constants for the SDRAM size probe and clear sequencer.
package sdram_probe_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_W2, S_W1, S_W0, S_WX, S_R2, S_R1, S_R0, S_FIN, S_CLR, S_DONE
  } state_e;

  typedef enum logic [1:0] {I_IDLE, I_STB, I_HOLD, I_WAIT} iss_e;

  localparam logic [15:0] MARK0 = 16'd1032;
  localparam logic [15:0] MARK1 = 16'd2064;
  localparam logic [15:0] MARK2 = 16'd3128;
  localparam logic [15:0] MARKX = 16'd12345;

  localparam logic [31:0] ADDR0 = 32'h000_0000;
  localparam logic [31:0] ADDRX = 32'h100_0000;
  localparam logic [31:0] ADDR1 = 32'h200_0000;
  localparam logic [31:0] ADDR2 = 32'h400_0000;

  localparam int CFG_OK0 = 0;
  localparam int CFG_OK1 = 1;
  localparam int CFG_OK2 = 2;
  localparam int CFG_VLD = 15;

  // Largest marker that read back intact bounds the populated range.
  function automatic logic [31:0] size_top(input logic [15:0] cfg);
    if (cfg[CFG_OK2])      return ADDR2;
    else if (cfg[CFG_OK1]) return ADDR1;
    else if (cfg[CFG_OK0]) return ADDRX;
    else                   return 32'h0;
  endfunction

endpackage

// File: rtl/sdram_probe_if.sv
// SDRAM command port: master is the probe sequencer, slave the SDRAM controller.
interface sdram_probe_if #(
  parameter int ADDR_W = 27,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;
  logic              mem_we;
  logic              mem_rd;
  logic              mem_ready;

  modport master (output mem_addr, mem_din, mem_we, mem_rd, input mem_ready, mem_dout);
  modport slave  (input mem_addr, mem_din, mem_we, mem_rd, output mem_ready, mem_dout);
endinterface

// File: rtl/sdram_cmd_issuer.sv
// One-command-at-a-time strobe / hold / wait handshake with a throttle gap counter.
module sdram_cmd_issuer
  import sdram_probe_pkg::*;
#(
  parameter int ADDR_W  = 27,
  parameter int DATA_W  = 16,
  parameter int CLR_GAP = 32
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  sdram_probe_if.master     mem,
  input  logic              req_i,
  input  logic              is_read_i,
  input  logic              throttle_i,
  input  logic              gap_en_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] din_i,
  output logic              ack_o
);
  localparam int GW = (CLR_GAP > 1) ? $clog2(CLR_GAP) : 1;

  iss_e              st_q, st_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              pend_q, pend_d;
  logic              we_q, rd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;
  logic              wrap, go;

  assign wrap  = gap_en_i && (gap_q == GW'(CLR_GAP - 1));
  // A throttled command waits for a wrap, or for readiness after a missed wrap.
  assign go    = (st_q == I_IDLE) && req_i && mem.mem_ready && (!throttle_i || wrap || pend_q);
  assign ack_o = (st_q == I_WAIT) && mem.mem_ready;

  always_comb begin
    st_d   = st_q;
    gap_d  = '0;
    pend_d = 1'b0;
    case (st_q)
      I_IDLE:  if (go) st_d = I_STB;
      I_STB:   st_d = I_HOLD;
      I_HOLD:  st_d = I_WAIT;
      I_WAIT:  if (mem.mem_ready) st_d = I_IDLE;
      default: st_d = I_IDLE;
    endcase
    if (gap_en_i) begin
      gap_d  = ((go && throttle_i) || wrap) ? '0 : gap_q + 1'b1;
      pend_d = (go && throttle_i) ? 1'b0 : (pend_q || wrap);
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= I_IDLE;
      gap_q  <= '0;
      pend_q <= 1'b0;
      we_q   <= 1'b0;
      rd_q   <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
    end else begin
      st_q   <= st_d;
      gap_q  <= gap_d;
      pend_q <= pend_d;
      we_q   <= go && !is_read_i;
      rd_q   <= go && is_read_i;
      if (go) begin
        addr_q <= addr_i;
        din_q  <= din_i;
      end
    end
  end

  assign mem.mem_we   = we_q;
  assign mem.mem_rd   = rd_q;
  assign mem.mem_addr = addr_q;
  assign mem.mem_din  = din_q;

endmodule

// File: rtl/sdram_probe_ctrl.sv
// Power-up SDRAM size probe followed by a throttled zero-fill of the detected range.
// Define SDRAM_PROBE_VERIFY_EN to read back every clear write and flag the first bad address.
module sdram_probe_ctrl
  import sdram_probe_pkg::*;
#(
  parameter int                ADDR_W  = 27,
  parameter int                DATA_W  = 16,
  parameter int                CLR_GAP = 32,
  parameter logic [DATA_W-1:0] M0      = DATA_W'(MARK0),
  parameter logic [DATA_W-1:0] M1      = DATA_W'(MARK1),
  parameter logic [DATA_W-1:0] M2      = DATA_W'(MARK2),
  parameter logic [DATA_W-1:0] MX      = DATA_W'(MARKX)
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              start,
  sdram_probe_if.master     mem,
  output logic [15:0]       cfg,
  output logic              clr_busy,
  output logic              clr_done
`ifdef SDRAM_PROBE_VERIFY_EN
  ,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr
`endif
);
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  state_e            st_q, st_d;
  logic [15:0]       cfg_q, cfg_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d, top_q, top_d;
  logic              done_q, done_d;
  logic              req, is_rd, ack, adv, throttle;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;

`ifdef SDRAM_PROBE_VERIFY_EN
  logic              vrd_q, vrd_d, err_q, err_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  assign throttle = (st_q == S_CLR) && !vrd_q;
`else
  assign throttle = (st_q == S_CLR);
`endif

  sdram_cmd_issuer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLR_GAP(CLR_GAP)) u_iss (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .mem       (mem),
    .req_i     (req),
    .is_read_i (is_rd),
    .throttle_i(throttle),
    .gap_en_i  (st_q == S_CLR),
    .addr_i    (addr),
    .din_i     (din),
    .ack_o     (ack)
  );

  always_comb begin
    st_d       = st_q;
    cfg_d      = cfg_q;
    clr_addr_d = clr_addr_q;
    top_d      = top_q;
    done_d     = done_q;
    req        = 1'b0;
    is_rd      = 1'b0;
    addr       = '0;
    din        = '0;
    adv        = 1'b0;
`ifdef SDRAM_PROBE_VERIFY_EN
    vrd_d      = vrd_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
`endif
    case (st_q)
      S_IDLE: begin
        cfg_d = '0;
        if (start && mem.mem_ready) st_d = S_W2;
      end
      S_W2: begin req = 1'b1; addr = ADDR_W'(ADDR2); din = M2; if (ack) st_d = S_W1; end
      S_W1: begin req = 1'b1; addr = ADDR_W'(ADDR1); din = M1; if (ack) st_d = S_W0; end
      S_W0: begin req = 1'b1; addr = ADDR_W'(ADDR0); din = M0; if (ack) st_d = S_WX; end
      S_WX: begin req = 1'b1; addr = ADDR_W'(ADDRX); din = MX; if (ack) st_d = S_R2; end
      S_R2: begin
        req = 1'b1; is_rd = 1'b1; addr = ADDR_W'(ADDR2);
        if (ack) begin cfg_d[CFG_OK2] = (mem.mem_dout == M2); st_d = S_R1; end
      end
      S_R1: begin
        req = 1'b1; is_rd = 1'b1; addr = ADDR_W'(ADDR1);
        if (ack) begin cfg_d[CFG_OK1] = (mem.mem_dout == M1); st_d = S_R0; end
      end
      S_R0: begin
        req = 1'b1; is_rd = 1'b1; addr = ADDR_W'(ADDR0);
        if (ack) begin cfg_d[CFG_OK0] = (mem.mem_dout == M0); st_d = S_FIN; end
      end
      S_FIN: begin
        cfg_d[CFG_VLD] = 1'b1;
        top_d          = ADDR_W'(size_top(cfg_q));
        clr_addr_d     = '0;
        if (top_d == '0) begin done_d = 1'b1; st_d = S_DONE; end
        else             st_d = S_CLR;
      end
      S_CLR: begin
        req  = 1'b1;
        addr = clr_addr_q;
`ifdef SDRAM_PROBE_VERIFY_EN
        is_rd = vrd_q;
        adv   = ack && vrd_q;
        if (ack) vrd_d = !vrd_q;
        if (adv && (mem.mem_dout != '0) && !err_q) begin
          err_d      = 1'b1;
          err_addr_d = clr_addr_q;
        end
`else
        adv = ack;
`endif
        if (adv) begin
          if (clr_addr_q == top_q - 1'b1) begin done_d = 1'b1; st_d = S_DONE; end
          else clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      S_DONE:  st_d = S_DONE;
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= S_IDLE;
      cfg_q      <= '0;
      clr_addr_q <= '0;
      top_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      st_q       <= st_d;
      cfg_q      <= cfg_d;
      clr_addr_q <= clr_addr_d;
      top_q      <= top_d;
      done_q     <= done_d;
    end
  end

`ifdef SDRAM_PROBE_VERIFY_EN
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      vrd_q      <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      vrd_q      <= vrd_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end
  assign err      = err_q;
  assign err_addr = err_addr_q;
`endif

  assign cfg      = cfg_q;
  assign clr_busy = (st_q == S_CLR);
  assign clr_done = done_q;

endmodule

// File: tb/tb_sdram_probe_ctrl.sv
// Directed bench: behavioural SDRAM model with aliasing, slow-ready and fault knobs.
module tb_sdram_probe_ctrl;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] cfg;
  logic        clr_busy, clr_done;
`ifdef SDRAM_PROBE_VERIFY_EN
  logic        err;
  logic [26:0] err_addr;
`endif

  sdram_probe_if #(.ADDR_W(27), .DATA_W(16)) mif ();

  sdram_probe_ctrl #(.ADDR_W(27), .DATA_W(16), .CLR_GAP(32)) dut (
    .clk_sys (clk),
    .reset_n (reset_n),
    .start   (start),
    .mem     (mif),
    .cfg     (cfg),
    .clr_busy(clr_busy),
    .clr_done(clr_done)
`ifdef SDRAM_PROBE_VERIFY_EN
    ,
    .err     (err),
    .err_addr(err_addr)
`endif
  );

  always #5 clk = ~clk;

  // Model knobs
  int          lat = 2;
  logic        spur = 1'b0, hold_low = 1'b0, garble = 1'b0, force5 = 1'b0;
  logic [26:0] amask = '1;
  logic [15:0] model_mem [int];
  int          since = 1000;
  int          cyc = 0;

  function automatic logic [15:0] rd_val(input logic [26:0] a);
    logic [15:0] v;
    int k;
    k = int'(a & amask);
    v = model_mem.exists(k) ? model_mem[k] : 16'h0;
    if (force5 && a == 27'h5) v = 16'hFFFF;
    return garble ? (v ^ 16'h0001) : v;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mif.mem_we) model_mem[int'(mif.mem_addr & amask)] = mif.mem_din;
    if (mif.mem_rd) mif.mem_dout <= rd_val(mif.mem_addr);
    if (mif.mem_we || mif.mem_rd) since = 0;
    else if (since < 1000) since++;
    mif.mem_ready <= !hold_low && ((since >= lat) || (spur && since == 0));
  end

  // Strobe monitor
  logic        p_we[$];
  logic [26:0] p_addr[$];
  logic [15:0] p_din[$];
  int          p_cyc[$];
  logic [26:0] cw_addr[$];
  int          cw_cyc[$];
  logic [26:0] cr_addr[$];
  int          viol = 0;
  logic        prev_stb = 1'b0;

  always @(negedge clk) begin
    if (mif.mem_we || mif.mem_rd) begin
      if (mif.mem_ready !== 1'b1) viol++;
      if (prev_stb) viol++;
      if (mif.mem_we && mif.mem_rd) viol++;
      if (!clr_busy) begin
        p_we.push_back(mif.mem_we);
        p_addr.push_back(mif.mem_addr);
        p_din.push_back(mif.mem_din);
        p_cyc.push_back(cyc);
      end else if (mif.mem_we) begin
        if (mif.mem_din !== 16'h0) viol++;
        cw_addr.push_back(mif.mem_addr);
        cw_cyc.push_back(cyc);
      end else begin
        cr_addr.push_back(mif.mem_addr);
      end
    end
    prev_stb = mif.mem_we || mif.mem_rd;
  end

  int n_assert = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [26:0] pa(input int i);
    case (i)
      0, 4:    return 27'h4000000;
      1, 5:    return 27'h2000000;
      3:       return 27'h1000000;
      default: return 27'h0;
    endcase
  endfunction

  function automatic logic [15:0] pd(input int i);
    case (i)
      0:       return 16'd3128;
      1:       return 16'd2064;
      2:       return 16'd1032;
      default: return 16'd12345;
    endcase
  endfunction

  task automatic check_probe(input string pfx);
    chk({pfx, "_count"}, 64'(p_addr.size()), 64'd7);
    if (p_addr.size() >= 7)
      for (int i = 0; i < 7; i++) begin
        chk($sformatf("%s_op%0d", pfx, i), {p_we[i], p_addr[i]}, {(i < 4), pa(i)});
        if (i < 4) chk($sformatf("%s_din%0d", pfx, i), p_din[i], pd(i));
      end
  endtask

  task automatic clear_q();
    p_we.delete(); p_addr.delete(); p_din.delete(); p_cyc.delete();
    cw_addr.delete(); cw_cyc.delete(); cr_addr.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0; start = 1'b0; hold_low = 1'b0;
    repeat (3) @(negedge clk);
    clear_q();
    model_mem.delete();
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_busy(input string tag, input int lim);
    int n = 0;
    while (!clr_busy && n < lim) begin @(negedge clk); n++; end
    chk(tag, clr_busy, 1'b1);
  endtask

  task automatic wait_cw(input string tag, input int n, input int lim);
    int k = 0;
    while (cw_addr.size() < n && k < lim) begin @(negedge clk); k++; end
    chk(tag, 64'(cw_addr.size() >= n), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, k;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_cfg", cfg, 16'h0);
    chk("rst_we", mif.mem_we, 1'b0);
    chk("rst_rd", mif.mem_rd, 1'b0);
    chk("rst_addr", mif.mem_addr, 27'h0);
    chk("rst_busy", clr_busy, 1'b0);
    chk("rst_done", clr_done, 1'b0);

    // Full model; start dropped mid-sequence; clear throttle and deferred write
    do_reset();
    start = 1'b1;
    k = 0;
    while (p_addr.size() < 2 && k < 100) begin @(negedge clk); k++; end
    start = 1'b0;
    wait_busy("full_busy", 400);
    chk("full_cfg", cfg, 16'h8007);
    check_probe("full");
    wait_cw("full_cw2", 2, 200);
    if (cw_addr.size() >= 2) begin
      chk("clr_a0", cw_addr[0], 27'h0);
      chk("clr_a1", cw_addr[1], 27'h1);
      chk("clr_gap", 64'(cw_cyc[1] - cw_cyc[0]), 64'd32);
      s = cw_cyc[1];
      while (cyc < s + 24) @(negedge clk);
      hold_low = 1'b1;
      while (cyc < s + 39) @(negedge clk);
      hold_low = 1'b0;
      wait_cw("full_cw4", 4, 200);
      if (cw_addr.size() >= 4) begin
        chk("clr_deferred", 64'(cw_cyc[2] - s), 64'd41);
        chk("clr_restart", 64'(cw_cyc[3] - cw_cyc[2]), 64'd32);
        chk("clr_a3", cw_addr[3], 27'h3);
        chk("addr_hold", mif.mem_addr, 27'h3);
      end
    end
`ifndef SDRAM_PROBE_VERIFY_EN
    chk("clr_no_reads", 64'(cr_addr.size()), 64'd0);
`else
    if (cr_addr.size() >= 1) chk("clr_vread0", cr_addr[0], 27'h0);
    else chk("clr_vread_cnt", 64'(cr_addr.size()), 64'd1);
`endif
    chk("full_busy2", clr_busy, 1'b1);
    chk("full_done", clr_done, 1'b0);

    // 25-bit part: upper markers alias onto address 0
    do_reset();
    amask = 27'h1FFFFFF;
    start = 1'b1;
    wait_busy("alias_busy", 400);
    chk("alias_cfg", cfg, 16'h8001);
    wait_cw("alias_cw1", 1, 100);
    if (cw_addr.size() >= 1) chk("alias_clr_a0", cw_addr[0], 27'h0);
    amask = '1;

    // Slow ready with a spurious pulse in the hold cycle
    do_reset();
    lat = 10; spur = 1'b1;
    start = 1'b1;
    wait_busy("slow_busy", 600);
    chk("slow_cfg", cfg, 16'h8007);
    check_probe("slow");
    if (p_cyc.size() >= 7)
      for (int i = 1; i < 7; i++)
        chk($sformatf("slow_gap%0d", i), 64'(p_cyc[i] - p_cyc[i-1]), 64'd13);
    lat = 2; spur = 1'b0;

    // Reset while the R1 read strobe is on the bus
    do_reset();
    start = 1'b1;
    k = 0;
    while (!(mif.mem_rd && mif.mem_addr == 27'h2000000) && k < 300) begin @(negedge clk); k++; end
    chk("r1_seen", mif.mem_rd, 1'b1);
    chk("r1_cfg_pre", cfg, 16'h0004);
    reset_n = 1'b0;
    #1;
    chk("r1_rst_rd", mif.mem_rd, 1'b0);
    chk("r1_rst_we", mif.mem_we, 1'b0);
    chk("r1_rst_cfg", cfg, 16'h0);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    clear_q();
    repeat (20) @(negedge clk);
    chk("r1_no_start", 64'(p_addr.size()), 64'd0);
    start = 1'b1;
    wait_busy("r1_busy", 400);
    chk("r1_cfg", cfg, 16'h8007);
    check_probe("r1");

    // No marker survives: empty range, clear skipped
    do_reset();
    garble = 1'b1;
    start = 1'b1;
    k = 0;
    while (!clr_done && k < 300) begin @(negedge clk); k++; end
    chk("none_done", clr_done, 1'b1);
    chk("none_cfg", cfg, 16'h8000);
    chk("none_busy", clr_busy, 1'b0);
    repeat (50) @(negedge clk);
    chk("none_no_clr", 64'(cw_addr.size()), 64'd0);
    chk("none_done_sticky", clr_done, 1'b1);
    garble = 1'b0;

`ifdef SDRAM_PROBE_VERIFY_EN
    // Read-back verify with a stuck word at address 5
    do_reset();
    force5 = 1'b1;
    start = 1'b1;
    wait_busy("ver_busy", 400);
    wait_cw("ver_cw5", 5, 400);
    chk("ver_err_pre", err, 1'b0);
    wait_cw("ver_cw8", 8, 400);
    chk("ver_err", err, 1'b1);
    chk("ver_err_addr", err_addr, 27'h5);
    if (cw_addr.size() >= 8) chk("ver_continue", cw_addr[7], 27'h7);
    chk("ver_still_busy", clr_busy, 1'b1);
    force5 = 1'b0;
`endif

    chk("protocol_viol", 64'(viol), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
